piece_pos_ctrl: RTL and testbench

Parametrised active-piece position/rotation controller for the Tetris datapath. It turns player requests (drop, left, right, rotate) and an internal gravity timer into candidate moves. Each candidate is validated against field bounds and an external collision checker through a valid/done handshake. Accepted moves are committed, and a blocked downward move locks the piece and respawns it.

---
 rtl/piece_pos_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_piece_pos_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_pos_ctrl.sv
// piece_pos_ctrl: position and rotation controller for the active Tetris piece.
// Player requests and a gravity timer become candidate moves. The block bounds-checks
// each candidate and hands it to an external collision checker. A checker hit on a
// downward move locks the piece, and the piece then respawns at the spawn pose.
module piece_pos_ctrl #(
  parameter int COLS     = 20,
  parameter int ROWS     = 30,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int ROT_W    = 2,
  parameter int SPAWN_X  = 9,
  parameter int SPAWN_Y  = 0,
  parameter int GRAV_DIV = 50
) (
  input  logic             clk,
  input  logic             err,
  input  logic             drop,
  input  logic             left,
  input  logic             right,
  input  logic             ro,
  input  logic             chk_done,
  input  logic             chk_hit,
  output logic             cand_valid,
  output logic [X_W-1:0]   cand_x,
  output logic [Y_W-1:0]   cand_y,
  output logic [ROT_W-1:0] cand_rot,
  output logic [X_W-1:0]   block_pos_x_out,
  output logic [Y_W-1:0]   block_pos_y_out,
  output logic [ROT_W-1:0] rotate,
  output logic             lock,
  output logic             busy
);

  localparam int CNT_W = $clog2(GRAV_DIV);

  localparam logic [X_W-1:0]   X_MAX    = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(ROWS - 1);
  localparam logic [X_W-1:0]   X_SPAWN  = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0]   Y_SPAWN  = Y_W'(SPAWN_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(GRAV_DIV - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   grav_cnt;
  logic               grav_pend;
  logic               mv_down;
  logic               issue_down;
  logic               load;
  logic [X_W-1:0]     n_cx;
  logic [Y_W-1:0]     n_cy;
  logic [ROT_W-1:0]   n_cr;

  // State register; reset abandons any in-flight check.
  always_ff @(posedge clk) begin
    if (err) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Arbitrate requests in IDLE, bounds-check them, and follow the checker's verdict.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    issue_down = 1'b0;
    n_cx       = block_pos_x_out;
    n_cy       = block_pos_y_out;
    n_cr       = rotate;
    case (state)
      IDLE: begin
        if (drop || grav_pend) begin
          issue_down = 1'b1;
          if (block_pos_y_out == Y_MAX) begin
            state_n = LOCK;
          end else begin
            load    = 1'b1;
            n_cy    = block_pos_y_out + 1'b1;
            state_n = CHECK;
          end
        end else if (left) begin
          if (block_pos_x_out != '0) begin
            load    = 1'b1;
            n_cx    = block_pos_x_out - 1'b1;
            state_n = CHECK;
          end
        end else if (right) begin
          if (block_pos_x_out != X_MAX) begin
            load    = 1'b1;
            n_cx    = block_pos_x_out + 1'b1;
            state_n = CHECK;
          end
        end else if (ro) begin
          load    = 1'b1;
          n_cr    = rotate + 1'b1;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (chk_done) begin
          if (chk_hit && mv_down) begin
            state_n = LOCK;
          end else begin
            state_n = IDLE;
          end
        end
      end
      LOCK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state, so they never glitch.
  always_comb begin
    cand_valid = (state == CHECK);
    lock       = (state == LOCK);
    busy       = (state != IDLE);
  end

  // Gravity timer; pend is raised as the count reaches its last value, so a
  // downward move issued from pend repeats every GRAV_DIV cycles.
  always_ff @(posedge clk) begin
    if (err) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else if (issue_down || state == LOCK) begin
      grav_cnt  <= '0;
      grav_pend <= 1'b0;
    end else if (grav_cnt == CNT_LAST) begin
      grav_cnt <= '0;
    end else begin
      grav_cnt <= grav_cnt + 1'b1;
      if (grav_cnt == CNT_PRE) begin
        grav_pend <= 1'b1;
      end
    end
  end

  // Pose datapath: load the candidate, commit it on a clean check, respawn after a lock.
  always_ff @(posedge clk) begin
    if (err) begin
      block_pos_x_out <= X_SPAWN;
      block_pos_y_out <= Y_SPAWN;
      rotate          <= '0;
      cand_x          <= X_SPAWN;
      cand_y          <= Y_SPAWN;
      cand_rot        <= '0;
      mv_down         <= 1'b0;
    end else begin
      if (load) begin
        cand_x   <= n_cx;
        cand_y   <= n_cy;
        cand_rot <= n_cr;
        mv_down  <= issue_down;
      end
      if (state == CHECK && chk_done && !chk_hit) begin
        block_pos_x_out <= cand_x;
        block_pos_y_out <= cand_y;
        rotate          <= cand_rot;
      end
      if (state == LOCK) begin
        block_pos_x_out <= X_SPAWN;
        block_pos_y_out <= Y_SPAWN;
        rotate          <= '0;
        cand_x          <= X_SPAWN;
        cand_y          <= Y_SPAWN;
        cand_rot        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_piece_pos_ctrl.sv
// tb_piece_pos_ctrl: scenario tasks plus a random run. A move-level model of the
// piece (pose, pending candidate, landing flag, elapsed gravity time) predicts
// every cycle's outputs.
module tb_piece_pos_ctrl;

  localparam int COLS    = 20;
  localparam int ROWS    = 30;
  localparam int X_W     = 10;
  localparam int Y_W     = 10;
  localparam int ROT_W   = 2;
  localparam int SPAWN_X = 9;
  localparam int SPAWN_Y = 0;
  localparam int GRAV    = 8;
  localparam int ROTN    = 1 << ROT_W;

  logic             clk = 1'b0;
  logic             err, drop, left, right, ro, chk_done, chk_hit;
  logic             cand_valid, lock, busy;
  logic [X_W-1:0]   cand_x, block_pos_x_out;
  logic [Y_W-1:0]   cand_y, block_pos_y_out;
  logic [ROT_W-1:0] cand_rot, rotate;

  int n_tests = 0;
  int n_fail  = 0;

  int mx, my, mr;
  int px, py, pr;
  bit m_wait, m_land, m_pdown;
  int g_elapsed;
  bit g_pend;

  piece_pos_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .X_W(X_W), .Y_W(Y_W), .ROT_W(ROT_W),
    .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y), .GRAV_DIV(GRAV)
  ) dut (
    .clk(clk), .err(err), .drop(drop), .left(left), .right(right), .ro(ro),
    .chk_done(chk_done), .chk_hit(chk_hit), .cand_valid(cand_valid),
    .cand_x(cand_x), .cand_y(cand_y), .cand_rot(cand_rot),
    .block_pos_x_out(block_pos_x_out), .block_pos_y_out(block_pos_y_out),
    .rotate(rotate), .lock(lock), .busy(busy)
  );

  always #5 clk = ~clk;

  // One clock edge of the game rules applied to the model.
  task automatic model_step(input bit e, d, l, r, o, cd, ch);
    bit down_issued;
    down_issued = 1'b0;
    if (e) begin
      mx = SPAWN_X; my = SPAWN_Y; mr = 0;
      m_wait = 0; m_land = 0; g_elapsed = 0; g_pend = 0;
      return;
    end
    if (m_land) begin
      m_land = 0;
      mx = SPAWN_X; my = SPAWN_Y; mr = 0;
      g_elapsed = 0; g_pend = 0;
      return;
    end
    if (m_wait) begin
      if (cd) begin
        m_wait = 0;
        if (!ch) begin
          mx = px; my = py; mr = pr;
        end else if (m_pdown) begin
          m_land = 1;
        end
      end
    end else if (d || g_pend) begin
      down_issued = 1'b1;
      if (my == ROWS - 1) m_land = 1;
      else begin
        px = mx; py = my + 1; pr = mr; m_pdown = 1; m_wait = 1;
      end
    end else if (l) begin
      if (mx > 0) begin
        px = mx - 1; py = my; pr = mr; m_pdown = 0; m_wait = 1;
      end
    end else if (r) begin
      if (mx < COLS - 1) begin
        px = mx + 1; py = my; pr = mr; m_pdown = 0; m_wait = 1;
      end
    end else if (o) begin
      px = mx; py = my; pr = (mr + 1) % ROTN; m_pdown = 0; m_wait = 1;
    end
    if (down_issued) begin
      g_elapsed = 0; g_pend = 0;
    end else begin
      g_elapsed = (g_elapsed + 1) % GRAV;
      if (g_elapsed == GRAV - 1) g_pend = 1;
    end
  endtask

  function automatic logic [46:0] exp_vec();
    logic [21:0] c;
    c = '0;
    if (m_wait) c = {X_W'(px), Y_W'(py), ROT_W'(pr)};
    return {m_wait, m_land, m_wait | m_land, X_W'(mx), Y_W'(my), ROT_W'(mr), c};
  endfunction

  function automatic logic [46:0] obs_vec();
    logic [21:0] c;
    c = '0;
    if (cand_valid) c = {cand_x, cand_y, cand_rot};
    return {cand_valid, lock, busy, block_pos_x_out, block_pos_y_out, rotate, c};
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, settle on the falling edge.
  task automatic cyc(input bit e, d, l, r, o, cd, ch);
    err = e; drop = d; left = l; right = r; ro = o; chk_done = cd; chk_hit = ch;
    @(posedge clk);
    model_step(e, d, l, r, o, cd, ch);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({cand_valid, lock, busy, block_pos_x_out, block_pos_y_out, rotate} !==
        {1'b0, 1'b0, 1'b0, 10'd9, 10'd0, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_state got %h want %h",
               {cand_valid, lock, busy, block_pos_x_out, block_pos_y_out, rotate},
               {1'b0, 1'b0, 1'b0, 10'd9, 10'd0, 2'd0});
    end
    n_tests++;
    if ({cand_x, cand_y, cand_rot} !== {10'd9, 10'd0, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL reset_cand got %h want %h", {cand_x, cand_y, cand_rot},
               {10'd9, 10'd0, 2'd0});
    end
  endtask

  task automatic test_left_walk();
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 1, 0, 0, 1, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL left_walk cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (block_pos_x_out !== 10'd0) begin
      n_fail++;
      $display("[TB] FAIL left_walk_end x got %0d want 0", block_pos_x_out);
    end
  endtask

  task automatic test_rotate();
    int want;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL rotate cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i % 2 == 0) begin
        want = (i / 2) % 4;
        n_tests++;
        if (rotate !== 2'(want)) begin
          n_fail++;
          $display("[TB] FAIL rotate_commit cyc %0d got %0d want %0d", i, rotate, want);
        end
      end else begin
        want = ((i + 1) / 2) % 4;
        n_tests++;
        if ({cand_valid, cand_rot} !== {1'b1, 2'(want)}) begin
          n_fail++;
          $display("[TB] FAIL rotate_cand cyc %0d got %0d want %0d", i, cand_rot, want);
        end
      end
    end
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    n = 0;
    while (!(my == 5 && !m_wait && !m_land) && n < 30) begin
      cyc(0, 1, 0, 0, 0, 1, 0);
      n++;
    end
    n_tests++;
    if (block_pos_y_out !== 10'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL prio_setup y got %0d want 5", block_pos_y_out);
    end
    cyc(0, 1, 1, 0, 1, 0, 0);
    n_tests++;
    if ({cand_valid, cand_x, cand_y, cand_rot} !== {1'b1, 10'd9, 10'd6, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL prio_cand got %h want %h", {cand_valid, cand_x, cand_y, cand_rot},
               {1'b1, 10'd9, 10'd6, 2'd0});
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if ({cand_valid, block_pos_x_out, block_pos_y_out, rotate} !== {1'b0, 10'd9, 10'd6, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL prio_commit got %h want %h",
               {cand_valid, block_pos_x_out, block_pos_y_out, rotate}, {1'b0, 10'd9, 10'd6, 2'd0});
    end
  endtask

  task automatic test_bottom_lock();
    int n;
    do_reset();
    n = 0;
    while (!(my == ROWS - 1 && !m_wait && !m_land) && n < 80) begin
      cyc(0, 1, 0, 0, 0, 1, 0);
      n++;
    end
    n_tests++;
    if (block_pos_y_out !== 10'd29) begin
      n_fail++;
      $display("[TB] FAIL bottom_setup y got %0d want 29", block_pos_y_out);
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    n_tests++;
    if ({lock, cand_valid, block_pos_x_out, block_pos_y_out} !== {1'b1, 1'b0, 10'd9, 10'd29}) begin
      n_fail++;
      $display("[TB] FAIL bottom_lock got %h want %h",
               {lock, cand_valid, block_pos_x_out, block_pos_y_out}, {1'b1, 1'b0, 10'd9, 10'd29});
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({lock, busy, block_pos_x_out, block_pos_y_out, rotate} !==
        {1'b0, 1'b0, 10'd9, 10'd0, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL bottom_respawn got %h want %h",
               {lock, busy, block_pos_x_out, block_pos_y_out, rotate},
               {1'b0, 1'b0, 10'd9, 10'd0, 2'd0});
    end
  endtask

  task automatic test_down_hit_delay();
    do_reset();
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({cand_valid, lock, cand_x, cand_y, cand_rot} !== {1'b1, 1'b0, 10'd9, 10'd1, 2'd0}) begin
        n_fail++;
        $display("[TB] FAIL hit_wait k %0d got %h want %h", k,
                 {cand_valid, lock, cand_x, cand_y, cand_rot}, {1'b1, 1'b0, 10'd9, 10'd1, 2'd0});
      end
      if (k < 3) cyc(0, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_tests++;
    if ({lock, cand_valid, block_pos_y_out} !== {1'b1, 1'b0, 10'd0}) begin
      n_fail++;
      $display("[TB] FAIL hit_lock got %h want %h", {lock, cand_valid, block_pos_y_out},
               {1'b1, 1'b0, 10'd0});
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (obs_vec() !== exp_vec() || lock !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hit_respawn got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_lateral_hit();
    do_reset();
    cyc(0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if ({cand_valid, cand_x} !== {1'b1, 10'd10}) begin
      n_fail++;
      $display("[TB] FAIL lat_cand got %h want %h", {cand_valid, cand_x}, {1'b1, 10'd10});
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    n_tests++;
    if ({lock, cand_valid, busy, block_pos_x_out} !== {1'b0, 1'b0, 1'b0, 10'd9}) begin
      n_fail++;
      $display("[TB] FAIL lat_hit got %h want %h", {lock, cand_valid, busy, block_pos_x_out},
               {1'b0, 1'b0, 1'b0, 10'd9});
    end
  endtask

  task automatic test_gravity();
    int rises[$];
    int want[6];
    bit prev;
    want = '{8, 16, 24, 29, 37, 45};
    do_reset();
    prev = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      cyc(0, (i == 29), 0, 0, 0, 1, 0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL gravity cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
      if (cand_valid && !prev) rises.push_back(i);
      prev = cand_valid;
    end
    n_tests++;
    if (rises.size() != 6) begin
      n_fail++;
      $display("[TB] FAIL grav_count got %0d want 6", rises.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (rises[k] != want[k]) begin
          n_fail++;
          $display("[TB] FAIL grav_time %0d got %0d want %0d", k, rises[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_err_mid_check();
    do_reset();
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if ({cand_valid, busy, block_pos_x_out, block_pos_y_out} !== {1'b0, 1'b0, 10'd9, 10'd0}) begin
      n_fail++;
      $display("[TB] FAIL err_abort got %h want %h",
               {cand_valid, busy, block_pos_x_out, block_pos_y_out}, {1'b0, 1'b0, 10'd9, 10'd0});
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if ({cand_valid, busy, block_pos_x_out} !== {1'b0, 1'b0, 10'd9}) begin
      n_fail++;
      $display("[TB] FAIL err_late_done got %h want %h", {cand_valid, busy, block_pos_x_out},
               {1'b0, 1'b0, 10'd9});
    end
  endtask

  task automatic test_random();
    bit e, d, l, r, o, cd, ch;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(0, 99) == 0);
      d  = ($urandom_range(0, 5) == 0);
      l  = $urandom_range(0, 1);
      r  = $urandom_range(0, 1);
      o  = $urandom_range(0, 1);
      cd = ($urandom_range(0, 2) != 0);
      ch = ($urandom_range(0, 3) == 0);
      cyc(e, d, l, r, o, cd, ch);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    err = 1'b1; drop = 0; left = 0; right = 0; ro = 0; chk_done = 0; chk_hit = 0;
    mx = SPAWN_X; my = SPAWN_Y; mr = 0; px = 0; py = 0; pr = 0;
    m_wait = 0; m_land = 0; m_pdown = 0; g_elapsed = 0; g_pend = 0;
    test_reset();
    test_left_walk();
    test_rotate();
    test_priority();
    test_bottom_lock();
    test_down_hit_delay();
    test_lateral_hit();
    test_gravity();
    test_err_mid_check();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
